// File: rtl/gate_selftest_sequencer.sv
// gate_selftest_sequencer: on-board self-test for the Liberty74 single-gate testboard.
// Walks {C,B,A} through all 8 combinations, holds each for SETTLE_CYCLES, samples the 16 gate
// results and compares them with golden values. Reports pass/fail, failing-vector count and a
// per-gate fail mask.
// Ports:
//   clk_i, rst_i (async, active-high), start_i (run request, ignored while busy_o)
//   result_i[15:0]  gate results in LED-bank order
//   stim_o[2:0]     stimulus {C,B,A}; stim_oe_o drives the nets when 1
//   busy_o, done_o, pass_o, err_cnt_o[ERR_W-1:0] (saturating), fail_mask_o[15:0]
// Optional macro SELFTEST_FIRST_FAIL_CAPTURE_EN adds first_fail_vld_o, first_fail_vec_o[2:0] and
// first_fail_data_o[15:0], holding the vector and raw results of the first failing sample of a run.
module gate_selftest_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [15:0]      result_i,
    output logic [2:0]       stim_o,
    output logic             stim_oe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
`ifdef SELFTEST_FIRST_FAIL_CAPTURE_EN
    output logic             first_fail_vld_o,
    output logic [2:0]       first_fail_vec_o,
    output logic [15:0]      first_fail_data_o,
`endif
    output logic [15:0]      fail_mask_o
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] settle_q, settle_d;
    logic [2:0] vec_q, vec_d, stim_d;
    logic stim_oe_d, busy_d, done_d, pass_d;
    logic [ERR_W-1:0] err_d;
    logic [15:0] mask_d, golden, mismatch;
    logic a, b, c;
`ifdef SELFTEST_FIRST_FAIL_CAPTURE_EN
    logic ff_vld_d;
    logic [2:0] ff_vec_d;
    logic [15:0] ff_data_d;
`endif
    assign {c, b, a} = vec_q;
    assign golden = {a ^ b ^ c, a ^ b, (a | b) & c, (a & b) | c, ~(a | b | c), ~(a | b), a | b | c, a | b,
                     ~(a & b & c), ~(a & b), a & b & c, a & b, c ? b : a, ~a, a, a};
    assign mismatch = result_i ^ golden;
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        vec_d     = vec_q;
        stim_d    = stim_o;
        stim_oe_d = stim_oe_o;
        busy_d    = busy_o;
        done_d    = done_o;
        pass_d    = pass_o;
        err_d     = err_cnt_o;
        mask_d    = fail_mask_o;
`ifdef SELFTEST_FIRST_FAIL_CAPTURE_EN
        ff_vld_d  = first_fail_vld_o;
        ff_vec_d  = first_fail_vec_o;
        ff_data_d = first_fail_data_o;
`endif
        case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d   = APPLY;
                settle_d  = '0;
                vec_d     = '0;
                stim_d    = '0;
                stim_oe_d = 1'b1;
                busy_d    = 1'b1;
                done_d    = 1'b0;
                pass_d    = 1'b0;
                err_d     = '0;
                mask_d    = '0;
`ifdef SELFTEST_FIRST_FAIL_CAPTURE_EN
                ff_vld_d  = 1'b0;
                ff_vec_d  = '0;
                ff_data_d = '0;
`endif
            end
            APPLY: begin
                settle_d = settle_q + 8'd1;
                stim_d   = vec_q;
                state_d  = (settle_q == 8'(SETTLE_CYCLES - 1)) ? SAMPLE : APPLY;
            end
            SAMPLE: begin
                mask_d = fail_mask_o | mismatch;
                if (mismatch != '0) begin
                    err_d = (err_cnt_o == '1) ? err_cnt_o : err_cnt_o + ERR_W'(1);
`ifdef SELFTEST_FIRST_FAIL_CAPTURE_EN
                    if (!first_fail_vld_o) begin
                        ff_vld_d  = 1'b1;
                        ff_vec_d  = vec_q;
                        ff_data_d = result_i;
                    end
`endif
                end
                if (vec_q == 3'd7) begin
                    state_d   = DONE;
                    stim_d    = '0;
                    stim_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = (err_d == '0);
                end else begin
                    state_d  = APPLY;
                    vec_d    = vec_q + 3'd1;
                    stim_d   = vec_q + 3'd1;
                    settle_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q           <= IDLE;
            settle_q          <= '0;
            vec_q             <= '0;
            stim_o            <= '0;
            stim_oe_o         <= 1'b0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            pass_o            <= 1'b0;
            err_cnt_o         <= '0;
            fail_mask_o       <= '0;
`ifdef SELFTEST_FIRST_FAIL_CAPTURE_EN
            first_fail_vld_o  <= 1'b0;
            first_fail_vec_o  <= '0;
            first_fail_data_o <= '0;
`endif
        end else begin
            state_q           <= state_d;
            settle_q          <= settle_d;
            vec_q             <= vec_d;
            stim_o            <= stim_d;
            stim_oe_o         <= stim_oe_d;
            busy_o            <= busy_d;
            done_o            <= done_d;
            pass_o            <= pass_d;
            err_cnt_o         <= err_d;
            fail_mask_o       <= mask_d;
`ifdef SELFTEST_FIRST_FAIL_CAPTURE_EN
            first_fail_vld_o  <= ff_vld_d;
            first_fail_vec_o  <= ff_vec_d;
            first_fail_data_o <= ff_data_d;
`endif
        end
    end
endmodule
